mux_sel_rr_arbiter: RTL and testbench

//   Round-robin arbiter that generates the 2-bit select for the downstream 4:1 data mux (mux4).

---
 rtl/mux_sel_rr_arbiter.sv | 117 +++++++++++
 tb/tb_mux_sel_rr_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter that drives the 2-bit select of a downstream 4:1 mux, with a hold-time watchdog.
// Latency: req -> grant/sel/busy is 1 cycle. On release the next grant follows on the next edge with no idle bubble.
// Backpressure: a requester keeps its grant until done, until it drops req, or until the watchdog revokes it.
module mux_sel_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Counter value seen in the last cycle a grant may last. Unused when MAX_HOLD is 0.
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state, state_nxt;
  logic [1:0]       sel_nxt;
  logic [3:0]       grant_nxt;
  logic             timeout_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             wd_hit;
  logic             release_now;
  logic [2:0]       pick_idle;
  logic [2:0]       pick_rel;

  // Round-robin search: first set bit of r starting at p+1 and wrapping to p.
  // Result is {found, index}. Scanning from the farthest offset down lets the nearest one win.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign busy = (state == GRANT);

  // Next-state, next-grant and watchdog decisions.
  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    grant_nxt   = grant;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
    wd_hit      = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    release_now = done || !req[sel] || wd_hit;
    pick_idle   = rr_pick(req, ptr);
    // The releasing channel is excluded so that a hog cannot immediately win again.
    pick_rel    = rr_pick(req & ~(4'b0001 << sel), ptr);
    case (state)
      IDLE: begin
        grant_nxt = 4'b0000;
        if (pick_idle[2]) begin
          state_nxt = GRANT;
          sel_nxt   = pick_idle[1:0];
          grant_nxt = 4'b0001 << pick_idle[1:0];
          ptr_nxt   = pick_idle[1:0];
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          // Only the watchdog can release while the holder still requests and has not signalled done.
          timeout_nxt = !done && req[sel];
          if (pick_rel[2]) begin
            sel_nxt   = pick_rel[1:0];
            grant_nxt = 4'b0001 << pick_rel[1:0];
            ptr_nxt   = pick_rel[1:0];
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
            grant_nxt = 4'b0000;
          end
        end else begin
          cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
      end
    endcase
  end

  // State and registered outputs. Pointer resets to 3 so the first search starts at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= 2'b00;
      grant   <= 4'b0000;
      timeout <= 1'b0;
      ptr     <= 2'd3;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      grant   <= grant_nxt;
      timeout <= timeout_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Bench for mux_sel_rr_arbiter: vector table, hand sequences for watchdog/reset/mux, randomized run vs model.
// Latency: checks are taken on the falling edge after each rising edge.
// Backpressure: not applicable; inputs are driven every cycle.
module tb_mux_sel_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: owner is -1 when idle, hold counts visible cycles of the current grant.
  int m_owner;
  int m_ptr;
  int m_sel;
  int m_hold;
  bit m_to;

  // Mux data inputs a..d as bits 0..3.
  logic [3:0] mux_data = 4'b0010;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl[27];

  always #5 clk = ~clk;

  mux_sel_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .done(done),
    .sel(sel),
    .grant(grant),
    .busy(busy),
    .timeout(timeout)
  );

  function automatic logic [7:0] outs();
    return {sel, grant, busy, timeout};
  endfunction

  function automatic logic mux_y();
    return mux_data[sel];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 3;
    m_sel   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    int w;
    bit to_n;
    to_n = 1'b0;
    if (m_owner < 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_ptr = w; m_sel = w; m_hold = 1;
      end
    end else if (d || !r[m_owner] || (MAXH > 0 && m_hold >= MAXH)) begin
      to_n = !d && r[m_owner];
      w = pick(r & ~(4'(1) << m_owner), m_ptr);
      if (w >= 0) begin
        m_owner = w; m_ptr = w; m_sel = w; m_hold = 1;
      end else begin
        m_owner = -1;
      end
    end else begin
      m_hold++;
    end
    m_to = to_n;
  endtask

  function automatic logic [7:0] model_outs();
    logic [3:0] g;
    g = (m_owner < 0) ? 4'b0000 : (4'(1) << m_owner);
    return {2'(m_sel), g, (m_owner >= 0), m_to};
  endfunction

  // Drive inputs at the falling edge, advance one rising edge, return at the next falling edge.
  task automatic cyc(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    if (!rst) model_step(r, d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    done = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] cur_req;
    logic [1:0] exp_sel;
    logic       exp_to;

    tbl[0]  = '{4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
    tbl[1]  = '{4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0};
    tbl[2]  = '{4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
    tbl[3]  = '{4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
    tbl[6]  = '{4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0};
    tbl[7]  = '{4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
    tbl[8]  = '{4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
    tbl[9]  = '{4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0};
    tbl[10] = '{4'b1111, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
    tbl[11] = '{4'b1111, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
    tbl[12] = '{4'b1111, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0};
    tbl[13] = '{4'b1111, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
    tbl[14] = '{4'b1111, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
    tbl[15] = '{4'b1111, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0};
    tbl[16] = '{4'b1111, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
    tbl[17] = '{4'b1111, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
    tbl[18] = '{4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0};
    tbl[19] = '{4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
    tbl[20] = '{4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
    tbl[21] = '{4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
    tbl[22] = '{4'b0011, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b1};
    tbl[23] = '{4'b0011, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
    tbl[24] = '{4'b0011, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0};
    tbl[25] = '{4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
    tbl[26] = '{4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};

    // Reset state.
    @(negedge clk);
    do_reset();
    check("reset_state", outs(), 8'b00_0000_0_0);

    // Single request, withdraw/lone re-grant, round robin, watchdog hand-over.
    for (int i = 0; i < 27; i++) begin
      cyc(tbl[i].req, tbl[i].done);
      check($sformatf("vec%0d", i), outs(), {tbl[i].sel, tbl[i].grant, tbl[i].busy, tbl[i].to});
    end

    // Watchdog from reset: ch0 for 4 cycles, timeout + ch1 for 4, timeout + back to ch0.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      cyc(4'b0011, 1'b0);
      exp_sel = (k <= 4) ? 2'd0 : ((k <= 8) ? 2'd1 : 2'd0);
      exp_to  = (k == 5) || (k == 9);
      check($sformatf("wdog%0d", k), outs(), {exp_sel, 4'b0001 << exp_sel, 1'b1, exp_to});
    end

    // Asynchronous reset mid-grant takes effect before any clock edge.
    do_reset();
    cyc(4'b0100, 1'b0);
    check("pre_arst_grant", outs(), {2'd2, 4'b0100, 1'b1, 1'b0});
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_mid_grant", outs(), 8'b00_0000_0_0);
    @(negedge clk);
    rst = 1'b0;
    cyc(4'b1111, 1'b0);
    check("first_after_rst", outs(), {2'd0, 4'b0001, 1'b1, 1'b0});

    // Mux integration: only b=1; y follows sel.
    do_reset();
    check("mux_idle_y", {7'd0, mux_y()}, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc(4'b0010, 1'b0);
      check($sformatf("mux_y%0d", k), {6'd0, busy, mux_y()}, 8'b11);
    end
    cyc(4'b0010, 1'b1);
    check("mux_release", {6'd0, busy, mux_y()}, 8'b01);

    // Randomized run against the model, with periodic resets.
    do_reset();
    cur_req = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      if (n % 600 == 599) do_reset();
      if ($urandom_range(0, 3) == 0) cur_req = 4'($urandom_range(0, 15));
      cyc(cur_req, ($urandom_range(0, 5) == 0));
      check($sformatf("rand%0d", n), outs(), model_outs());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
